// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with selectable bit order, a one-word output
// buffer with valid/ready handshake, and a sticky overrun flag.
module shift_deserializer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic [4:0]       bit_count,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             dir_lat;

    logic             accept;
    logic             eff_dir;
    logic             last_bit;
    logic             consume;
    logic [WIDTH-1:0] shreg_next;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             d,
                                                  input logic             b);
        if (d)
            return {b, cur[WIDTH-1:1]};
        else
            return {cur[WIDTH-2:0], b};
    endfunction

    // Bit order comes from the live input only on the first bit of a word.
    assign accept     = enable & serial_valid;
    assign eff_dir    = (state == IDLE) ? dir : dir_lat;
    assign last_bit   = accept && (bit_count == 5'(WIDTH - 1));
    assign consume    = word_valid & word_ready;
    assign shreg_next = shift_in(shreg, eff_dir, serial_in);
    assign busy       = (state == SHIFT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_count  <= '0;
            dir_lat    <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                if (state == IDLE)
                    dir_lat <= dir;
                if (last_bit) begin
                    shreg     <= '0;
                    bit_count <= '0;
                    state     <= IDLE;
                end else begin
                    shreg     <= shreg_next;
                    bit_count <= bit_count + 5'd1;
                    state     <= SHIFT;
                end
            end

            // Output buffer: a completing word loads only if the slot is free
            // or being consumed on this same edge; otherwise it is dropped.
            if (last_bit) begin
                if (!word_valid || consume) begin
                    word_out   <= shreg_next;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: bit order, gaps, handshake, overrun
// and reset behaviour with WIDTH=16.
module tb_shift_deserializer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        dir;
    logic        serial_in;
    logic        serial_valid;
    logic        word_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic [4:0]  bit_count;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    shift_deserializer #(.WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .dir          (dir),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .word_ready   (word_ready),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .bit_count    (bit_count),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic d);
        serial_in    = b;
        dir          = d;
        enable       = 1'b1;
        serial_valid = 1'b1;
        tick();
        serial_valid = 1'b0;
    endtask

    // MSB-first stream of w; word_ready driven high only on the final bit.
    task automatic send_word_msb(input logic [15:0] w, input logic rdy_last);
        for (int i = 15; i >= 0; i--) begin
            word_ready = (i == 0) ? rdy_last : 1'b0;
            send_bit(w[i], 1'b0);
        end
        word_ready = 1'b0;
    endtask

    task automatic consume_word();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; dir = 1'b0; serial_in = 1'b0;
        serial_valid = 1'b0; word_ready = 1'b0;
        #1;
        do_reset();
        tick();

        // Reset state
        check("rst_word_out", 32'(word_out), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_bit_count", 32'(bit_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // MSB-first 1,0,1,0...
        for (int i = 0; i < 15; i++) send_bit(~i[0], 1'b0);
        check("msb_cnt15", 32'(bit_count), 32'd15);
        check("msb_busy15", 32'(busy), 32'h1);
        check("msb_valid_early", 32'(word_valid), 32'h0);
        send_bit(1'b0, 1'b0);
        check("msb_word", 32'(word_out), 32'hAAAA);
        check("msb_valid", 32'(word_valid), 32'h1);
        check("msb_busy", 32'(busy), 32'h0);
        check("msb_cnt", 32'(bit_count), 32'h0);
        tick();
        check("msb_hold", 32'(word_out), 32'hAAAA);
        consume_word();
        check("msb_consumed", 32'(word_valid), 32'h0);

        // LSB-first 1,0,1,0...
        for (int i = 0; i < 16; i++) send_bit(~i[0], 1'b1);
        check("lsb_word", 32'(word_out), 32'h5555);
        consume_word();

        // dir flips after 4 bits; latched order must persist
        for (int i = 0; i < 16; i++) send_bit(~i[0], (i >= 4));
        check("flip_word", 32'(word_out), 32'hAAAA);
        consume_word();

        // Gaps: enable low (serial_valid noise ignored) or serial_valid low
        begin
            logic [15:0] w;
            w = 16'h1234;
            for (int i = 15; i >= 0; i--) begin
                send_bit(w[i], 1'b0);
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    serial_in    = 1'($urandom);
                    dir          = 1'($urandom);
                    enable       = g[0];
                    serial_valid = ~g[0];
                    tick();
                end
                if (i == 10) begin
                    enable = 1'b0; serial_valid = 1'b1; serial_in = 1'b1;
                    tick();
                    check("gap_cnt_hold_dis", 32'(bit_count), 32'd6);
                    enable = 1'b1; serial_valid = 1'b0;
                    tick();
                    check("gap_cnt_hold_nv", 32'(bit_count), 32'd6);
                    check("gap_busy", 32'(busy), 32'h1);
                end
            end
            enable = 1'b0; serial_valid = 1'b0;
            check("gap_word", 32'(word_out), 32'h1234);
        end
        // Handshake works with enable low
        enable = 1'b0;
        consume_word();
        check("dis_consume", 32'(word_valid), 32'h0);

        // Overrun
        send_word_msb(16'hAAAA, 1'b0);
        send_word_msb(16'h1234, 1'b0);
        check("ovr_word", 32'(word_out), 32'hAAAA);
        check("ovr_valid", 32'(word_valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        consume_word();
        check("ovr_consumed", 32'(word_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        tick();
        check("ovr_sticky2", 32'(overrun), 32'h1);

        // Simultaneous consume and complete
        do_reset();
        check("rst2_overrun", 32'(overrun), 32'h0);
        send_word_msb(16'hAAAA, 1'b0);
        send_word_msb(16'h00FF, 1'b1);
        check("sim_word", 32'(word_out), 32'h00FF);
        check("sim_valid", 32'(word_valid), 32'h1);
        check("sim_overrun", 32'(overrun), 32'h0);

        // Reset while a word is buffered
        do_reset();
        check("rstbuf_valid", 32'(word_valid), 32'h0);
        check("rstbuf_word", 32'(word_out), 32'h0);

        // Reset mid-word
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        check("mid_cnt7", 32'(bit_count), 32'd7);
        do_reset();
        check("mid_rst_cnt", 32'(bit_count), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        send_word_msb(16'hC3C3, 1'b0);
        check("mid_word", 32'(word_out), 32'hC3C3);
        check("mid_valid", 32'(word_valid), 32'h1);
        consume_word();

        // Reset wins over a completing bit on the same edge
        for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
        reset = 1'b1;
        send_bit(1'b1, 1'b0);
        reset = 1'b0;
        check("prio_valid", 32'(word_valid), 32'h0);
        check("prio_cnt", 32'(bit_count), 32'h0);
        check("prio_word", 32'(word_out), 32'h0);

        // Back-to-back words with no idle gap
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
        word_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_bit(i[0], 1'b0);
        word_ready = 1'b0;
        check("b2b_word", 32'(word_out), 32'h5555);
        check("b2b_valid", 32'(word_valid), 32'h1);
        check("b2b_overrun", 32'(overrun), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
